// File: rtl/text_buffer_if.sv
// Console write port and display read port of the 16x16 text buffer.
interface text_buffer_if;
  logic [7:0] wr_char;
  logic       wr_valid;
  logic       wr_ready;
  logic       clr;
  logic [7:0] char_xy;
  logic [7:0] char_code;
  logic [7:0] cursor_xy;
  logic       busy;

  modport master (
    output wr_char, wr_valid, clr, char_xy,
    input  wr_ready, char_code, cursor_xy, busy
  );

  modport slave (
    input  wr_char, wr_valid, clr, char_xy,
    output wr_ready, char_code, cursor_xy, busy
  );
endinterface

// File: rtl/text_buffer.sv
// 16x16 character screen buffer with console control codes and a display read port.
// Optional feature: define TEXT_BUFFER_SCROLL_EN to scroll instead of wrapping to row 0.
module text_buffer #(
  parameter logic [7:0]  CLEAR_CHAR = 8'h20,
  parameter int unsigned COLS       = 16,
  parameter int unsigned ROWS       = 16
) (
  input  logic         clk,
  input  logic         rst,
  text_buffer_if.slave bus
);
  localparam int unsigned CELLS = COLS * ROWS;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    CLEAR_ALL = 2'd1,
    CLEAR_ROW = 2'd2
  } state_t;

  state_t     state_r;
  logic [7:0] cnt_r;
  logic [3:0] row_r;
  logic [3:0] col_r;
  logic [3:0] offset_r;
  logic [3:0] clr_row_r;
  logic [7:0] char_code_r;
  logic [7:0] mem_r [CELLS];

  logic       wr_ready_s;
  logic       accept_s;
  logic       printable_s;
  logic [3:0] cur_phys_s;
  logic [3:0] adv_row_s;
  logic [3:0] adv_off_s;
  logic [3:0] adv_phys_s;
  logic       we_s;
  logic [7:0] waddr_s;
  logic [7:0] wdata_s;
  logic [7:0] rd_addr_s;

  assign wr_ready_s  = (state_r == IDLE) && !bus.clr;
  assign accept_s    = bus.wr_valid && wr_ready_s;
  assign printable_s = (bus.wr_char >= 8'h20) && (bus.wr_char <= 8'h7E);
  // Logical rows map onto physical rows rotated by the scroll offset.
  assign cur_phys_s  = row_r + offset_r;
  assign rd_addr_s   = {bus.char_xy[7:4] + offset_r, bus.char_xy[3:0]};

  assign bus.wr_ready  = wr_ready_s;
  assign bus.char_code = char_code_r;
  assign bus.cursor_xy = {row_r, col_r};
  assign bus.busy      = (state_r != IDLE);

  // Cursor row, scroll offset and physical row to blank after a row advance.
  always_comb begin
    adv_row_s = row_r + 4'd1;
    adv_off_s = offset_r;
`ifdef TEXT_BUFFER_SCROLL_EN
    if (row_r == 4'd15) begin
      adv_row_s = 4'd15;
      adv_off_s = offset_r + 4'd1;
    end else begin
      adv_row_s = row_r + 4'd1;
      adv_off_s = offset_r;
    end
`else
    adv_off_s = 4'd0;
`endif
    adv_phys_s = adv_row_s + adv_off_s;
  end

  // Single write port: clear sweeps own it while busy, console writes while idle.
  always_comb begin
    we_s    = 1'b0;
    waddr_s = 8'h00;
    wdata_s = CLEAR_CHAR;
    case (state_r)
      CLEAR_ALL: begin
        we_s    = 1'b1;
        waddr_s = cnt_r;
      end
      CLEAR_ROW: begin
        we_s    = 1'b1;
        waddr_s = {clr_row_r, cnt_r[3:0]};
      end
      IDLE: begin
        if (accept_s && printable_s) begin
          we_s    = 1'b1;
          waddr_s = {cur_phys_s, col_r};
          wdata_s = bus.wr_char;
        end else if (accept_s && (bus.wr_char == 8'h08) && (col_r != 4'd0)) begin
          we_s    = 1'b1;
          waddr_s = {cur_phys_s, col_r - 4'd1};
        end else begin
          we_s = 1'b0;
        end
      end
      default: we_s = 1'b0;
    endcase
  end

  // Character memory write port.
  always_ff @(posedge clk) begin
    if (we_s) begin
      mem_r[waddr_s] <= wdata_s;
    end
  end

  // Display read port, one cycle latency, independent of the write port.
  always_ff @(posedge clk) begin
    if (rst) begin
      char_code_r <= 8'h00;
    end else begin
      char_code_r <= mem_r[rd_addr_s];
    end
  end

  // Control FSM: cursor handling, control codes and clear sequencing.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= CLEAR_ALL;
      cnt_r     <= 8'd0;
      row_r     <= 4'd0;
      col_r     <= 4'd0;
      offset_r  <= 4'd0;
      clr_row_r <= 4'd0;
    end else begin
      case (state_r)
        IDLE: begin
          cnt_r <= 8'd0;
          if (bus.clr || (accept_s && (bus.wr_char == 8'h0C))) begin
            state_r  <= CLEAR_ALL;
            row_r    <= 4'd0;
            col_r    <= 4'd0;
            offset_r <= 4'd0;
          end else if (accept_s && ((bus.wr_char == 8'h0A) ||
                                    (printable_s && (col_r == 4'd15)))) begin
            state_r   <= CLEAR_ROW;
            col_r     <= 4'd0;
            row_r     <= adv_row_s;
            offset_r  <= adv_off_s;
            clr_row_r <= adv_phys_s;
          end else if (accept_s && (bus.wr_char == 8'h0D)) begin
            col_r <= 4'd0;
          end else if (accept_s && printable_s) begin
            col_r <= col_r + 4'd1;
          end else if (accept_s && (bus.wr_char == 8'h08) && (col_r != 4'd0)) begin
            col_r <= col_r - 4'd1;
          end
        end
        CLEAR_ALL: begin
          cnt_r <= cnt_r + 8'd1;
          if (cnt_r == 8'd255) begin
            state_r <= IDLE;
          end
        end
        CLEAR_ROW: begin
          if (bus.clr) begin
            state_r  <= CLEAR_ALL;
            cnt_r    <= 8'd0;
            row_r    <= 4'd0;
            col_r    <= 4'd0;
            offset_r <= 4'd0;
          end else begin
            cnt_r <= cnt_r + 8'd1;
            if (cnt_r == 8'd15) begin
              state_r <= IDLE;
            end
          end
        end
        default: begin
          state_r <= CLEAR_ALL;
          cnt_r   <= 8'd0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_text_buffer.sv
// Scoreboard bench for text_buffer: a screen model predicts display reads, cursor and clear lengths.
module tb_text_buffer;
  logic clk;
  logic rst;
  text_buffer_if bus ();

  text_buffer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference screen as seen by the display: logical cells, row 0 at top.
  logic [7:0] m_scr [256];
  int m_row = 0;
  int m_col = 0;

  logic [7:0] exp_q [$];
  logic       rd_vld = 1'b0;
  logic       rd_vld_d = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_clear_all();
    for (int i = 0; i < 256; i++) m_scr[i] = 8'h20;
    m_row = 0;
    m_col = 0;
  endtask

  task automatic model_blank_row(input int r);
    for (int c = 0; c < 16; c++) m_scr[r * 16 + c] = 8'h20;
  endtask

  task automatic model_row_adv(output int b);
    b = 16;
    if (m_row < 15) begin
      m_row = m_row + 1;
      model_blank_row(m_row);
    end else begin
`ifdef TEXT_BUFFER_SCROLL_EN
      for (int r = 0; r < 15; r++)
        for (int c = 0; c < 16; c++) m_scr[r * 16 + c] = m_scr[(r + 1) * 16 + c];
      model_blank_row(15);
`else
      m_row = 0;
      model_blank_row(0);
`endif
    end
  endtask

  task automatic model_put(input logic [7:0] c, output int b);
    b = 0;
    if (c >= 8'h20 && c <= 8'h7E) begin
      m_scr[m_row * 16 + m_col] = c;
      if (m_col == 15) begin
        m_col = 0;
        model_row_adv(b);
      end else begin
        m_col = m_col + 1;
      end
    end else if (c == 8'h0A) begin
      m_col = 0;
      model_row_adv(b);
    end else if (c == 8'h0D) begin
      m_col = 0;
    end else if (c == 8'h08) begin
      if (m_col != 0) begin
        m_col = m_col - 1;
        m_scr[m_row * 16 + m_col] = 8'h20;
      end
    end else if (c == 8'h0C) begin
      model_clear_all();
      b = 256;
    end
  endtask

  // Tasks start and end one time unit after a rising edge.
  task automatic wait_idle(input int exp_cycles, input string name);
    int n;
    n = 0;
    @(negedge clk);
    while (bus.busy === 1'b1 && n < 600) begin
      n++;
      @(negedge clk);
    end
    chk({name, "_busy_cycles"}, n, exp_cycles);
    chk({name, "_wr_ready"}, {31'd0, bus.wr_ready}, 1);
    chk({name, "_cursor"}, {24'd0, bus.cursor_xy}, m_row * 16 + m_col);
    @(posedge clk);
    #1;
  endtask

  task automatic send_char(input logic [7:0] c);
    int b;
    bus.wr_char  = c;
    bus.wr_valid = 1'b1;
    @(negedge clk);
    chk("wr_ready_before_accept", {31'd0, bus.wr_ready}, 1);
    @(posedge clk);
    #1;
    bus.wr_valid = 1'b0;
    bus.wr_char  = 8'($urandom);
    model_put(c, b);
    wait_idle(b, "char");
  endtask

  task automatic do_clr();
    bus.clr = 1'b1;
    @(posedge clk);
    #1;
    bus.clr = 1'b0;
    model_clear_all();
    wait_idle(256, "clr");
  endtask

  task automatic read_cell(input logic [7:0] xy);
    bus.char_xy = xy;
    rd_vld = 1'b1;
    exp_q.push_back(m_scr[xy]);
    @(posedge clk);
    #1;
    rd_vld = 1'b0;
  endtask

  task automatic dump();
    for (int i = 0; i < 256; i++) read_cell(8'(i));
  endtask

  // Monitor: a read issued in one cycle is compared on the following cycle.
  always @(posedge clk) rd_vld_d <= rd_vld;

  always @(negedge clk) begin
    if (rd_vld_d) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL char_code: got 0x%0h with no expected entry", bus.char_code);
      end else begin
        chk("char_code", {24'd0, bus.char_code}, {24'd0, exp_q.pop_front()});
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] others [6];
    int r;
    int b;
    others = '{8'h00, 8'h01, 8'h09, 8'h1B, 8'h7F, 8'hC3};
    rst = 1'b1;
    bus.wr_char = 8'h00;
    bus.wr_valid = 1'b0;
    bus.clr = 1'b0;
    bus.char_xy = 8'h00;
    model_clear_all();

    // Reset values and the power-up clear.
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst_wr_ready", {31'd0, bus.wr_ready}, 0);
    chk("rst_busy", {31'd0, bus.busy}, 1);
    chk("rst_cursor", {24'd0, bus.cursor_xy}, 0);
    chk("rst_char_code", {24'd0, bus.char_code}, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    wait_idle(256, "powerup");
    dump();

    // "AB" at the home position.
    send_char(8'h41);
    send_char(8'h42);
    read_cell(8'h00);
    read_cell(8'h01);
    read_cell(8'h02);

    // Line wrap after 16 characters.
    do_clr();
    for (int i = 0; i < 16; i++) send_char(8'h78);
    send_char(8'h79);
    for (int i = 0; i < 18; i++) read_cell(8'(i));

    // Backspace mid-line and at column 0.
    do_clr();
    send_char(8'h68); send_char(8'h65); send_char(8'h6C); send_char(8'h6C); send_char(8'h6F);
    send_char(8'h08);
    read_cell(8'h04);
    read_cell(8'h03);
    send_char(8'h0D);
    send_char(8'h08);
    read_cell(8'h00);

    // Line feed from the bottom row.
    do_clr();
    send_char(8'h61);
    send_char(8'h0A);
    send_char(8'h62);
    for (int i = 0; i < 14; i++) send_char(8'h0A);
    send_char(8'h63); send_char(8'h64); send_char(8'h65);
    send_char(8'h0A);
    dump();

    // clr and a character in the same cycle.
    send_char(8'h71);
    bus.clr = 1'b1;
    bus.wr_valid = 1'b1;
    bus.wr_char = 8'h5A;
    @(negedge clk);
    chk("clr_blocks_wr_ready", {31'd0, bus.wr_ready}, 0);
    @(posedge clk);
    #1;
    bus.clr = 1'b0;
    bus.wr_valid = 1'b0;
    model_clear_all();
    wait_idle(256, "clr_with_char");
    dump();

    // clr aborts a row clear.
    send_char(8'h51);
    bus.wr_char = 8'h0A;
    bus.wr_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.wr_valid = 1'b0;
    model_put(8'h0A, b);
    repeat (4) @(posedge clk);
    #1;
    bus.clr = 1'b1;
    @(posedge clk);
    #1;
    bus.clr = 1'b0;
    model_clear_all();
    wait_idle(256, "clr_abort_row");

    // clr during a full clear is ignored.
    bus.clr = 1'b1;
    @(posedge clk);
    #1;
    bus.clr = 1'b0;
    model_clear_all();
    repeat (99) @(posedge clk);
    #1;
    bus.clr = 1'b1;
    @(posedge clk);
    #1;
    bus.clr = 1'b0;
    wait_idle(156, "clr_during_clear_all");

    // Form feed, then reset during a row clear.
    send_char(8'h4B);
    send_char(8'h0C);
    read_cell(8'h00);
    send_char(8'h4D);
    bus.wr_char = 8'h0A;
    bus.wr_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.wr_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("midrst_busy", {31'd0, bus.busy}, 1);
    chk("midrst_wr_ready", {31'd0, bus.wr_ready}, 0);
    chk("midrst_cursor", {24'd0, bus.cursor_xy}, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_clear_all();
    wait_idle(256, "midrst");
    dump();

    // Randomized console traffic.
    for (int it = 0; it < 200; it++) begin
      r = $urandom_range(0, 99);
      if (r < 60)      send_char(8'($urandom_range(32, 126)));
      else if (r < 72) send_char(8'h0A);
      else if (r < 78) send_char(8'h0D);
      else if (r < 88) send_char(8'h08);
      else if (r < 98) send_char(others[$urandom_range(0, 5)]);
      else             send_char(8'h0C);
      read_cell(8'($urandom));
      read_cell(8'(m_row * 16 + m_col));
      if (it % 50 == 49) dump();
    end
    dump();

    repeat (2) @(posedge clk);
    #1;
    chk("scoreboard_drain", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/text_buffer.md
TEXT_BUFFER -- requirements
Module: text_buffer

Interface
REQ-001 SHALL have parameter CLEAR_CHAR, default 8'h20, the code written into cleared cells.
REQ-002 SHALL have parameter COLS, default 16, characters per row (fixed at 16; other values are not supported).
REQ-003 SHALL have parameter ROWS, default 16, rows in the grid (fixed at 16).
REQ-004 clk  in  1  clock; all logic on its rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 wr_char  in  8  character or control code from the console source.
REQ-007 wr_valid  in  1  wr_char is valid.
REQ-008 wr_ready  out  1  block accepts wr_char this cycle.
REQ-009 clr  in  1  one-cycle request to clear the whole screen.
REQ-010 char_xy  in  8  display read address {row[7:4], col[3:0]} from the glyph-drawing stage.
REQ-011 char_code  out  8  character at char_xy, fed to the font ROM address.
REQ-012 cursor_xy  out  8  current logical cursor {row, col}.
REQ-013 busy  out  1  a clear sequence is in progress.

Function
REQ-014 SHALL hold a 256 x 8 character memory with one write port (control FSM) and one read port (display).
REQ-015 SHALL register char_code exactly 1 cycle after char_xy; the read port is never stalled by writes or clears.
REQ-016 SHALL accept a character only when wr_valid && wr_ready; wr_ready = (state==IDLE) && !clr.
REQ-017 SHALL implement FSM states IDLE, CLEAR_ALL (256 cycles, one cell per cycle), and CLEAR_ROW (16 cycles); busy=1 outside IDLE.
REQ-018 Printable codes 8'h20..8'h7E SHALL be written at the cursor, then the cursor SHALL advance: col+1, or at col 15 col=0 and a row advance.
REQ-019 8'h0A (LF) SHALL cause col=0 and a row advance; 8'h0D (CR) SHALL cause col=0 only.
REQ-020 8'h08 (BS) SHALL decrement col and write CLEAR_CHAR at the new position; at col 0 it SHALL be a no-op.
REQ-021 8'h0C (FF) SHALL behave as clr; all other codes SHALL be accepted and discarded.
REQ-022 A row advance from row < 15 SHALL increment row, clear the new row via CLEAR_ROW, and return to IDLE.
REQ-023 A row advance from row 15 SHALL follow REQ-031/REQ-032.
REQ-024 clr in IDLE, or FF accepted, SHALL enter CLEAR_ALL, set cursor 0x00 and row offset 0, and return to IDLE after cell 255 is written.
REQ-025 clr during CLEAR_ROW SHALL abort it and enter CLEAR_ALL; clr during CLEAR_ALL SHALL be ignored.
REQ-026 clr and wr_valid in the same cycle: clr wins, and the character SHALL NOT be accepted.
REQ-027 Address arithmetic SHALL be modulo 16 per field (4-bit wrap); no out-of-range access.

Reset
REQ-028 During rst: wr_ready=0, char_code=0, cursor_xy=0, busy=1, row offset=0.
REQ-029 After rst deasserts, the FSM SHALL run CLEAR_ALL (256 cycles) before wr_ready rises.
REQ-030 rst asserted mid-sequence SHALL abort any clear and restart per REQ-028/REQ-029.

Configuration
REQ-031 With TEXT_BUFFER_SCROLL_EN defined: a row advance from row 15 SHALL increment a 4-bit row offset, keep cursor row 15, and clear physical row (15+offset) mod 16; display reads SHALL use physical row = char_xy[7:4]+offset mod 16, so text scrolls up by one line.
REQ-032 Without TEXT_BUFFER_SCROLL_EN: the row offset SHALL be constant 0, and a row advance from row 15 SHALL set row=0 and clear row 0.

Verification
REQ-033 Reset, then count cycles -> busy=1 for 256 cycles, then wr_ready=1; read any char_xy -> char_code=0x20 one cycle later.
REQ-034 Write "AB" -> char_xy 0x00 reads 0x41 and 0x01 reads 0x42; cursor_xy=0x02.
REQ-035 Write 16 'x', then 'y' -> 'y' lands at 0x10, after a 16-cycle busy pulse.
REQ-036 Cursor 0x05, BS -> cursor 0x04, cell 0x04=0x20; at cursor 0x00, BS -> no change.
REQ-037 Cursor 0xF3, LF: with SCROLL_EN -> cursor 0xF0, previous row 1 content is shown at char_xy row 0, row 15 blank; without -> cursor 0x00, row 0 blank.
REQ-038 clr and wr_valid='Z' in the same cycle -> wr_ready=0, 'Z' is not written, 256-cycle clear runs, cursor 0x00.
